// File: rtl/deca_irq_aggregator.sv
// Interrupt aggregator: per-source mask, edge/level mode, W1C pending, software force, prioritised vector.
// Optional IRQ_SYNC_EN adds a 2-flop synchroniser on every src bit ahead of edge detection.
module deca_irq_aggregator #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;
    localparam logic [2:0] ADDR_RAW     = 3'd6;

    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;

    logic               wr_en;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] force_bits;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] active;
    logic               vec_valid;
    logic [3:0]         vec_idx;
    logic [15:0]        vector;
    logic [15:0]        rd_mux;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync_a;
    logic [NUM_SRC-1:0] sync_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= src;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = src;
`endif

    // Upper write-data bits have no storage when fewer than 16 sources exist.
    generate
        if (NUM_SRC < 16) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[15:NUM_SRC];
        end
    endgenerate

    function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign wr_en      = chipselect & ~write_n;
    assign wdata      = writedata[NUM_SRC-1:0];
    assign clr_bits   = (wr_en && (address == ADDR_PENDING)) ? wdata : '0;
    assign force_bits = (wr_en && (address == ADDR_FORCE))   ? wdata : '0;
    assign rise       = s & ~src_d;

    // Edge sources: set beats clear. Level sources simply track s.
    assign pending_nxt = (mode & ((pending & ~clr_bits) | rise | force_bits))
                       | (~mode & s);

    assign active = pending & mask;

    always_comb begin
        vec_idx   = '0;
        vec_valid = |active;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 4'(i);
            end
        end
    end

    assign vector = vec_valid ? {1'b1, 11'b0, vec_idx} : 16'h0000;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING: rd_mux = zext(pending);
            ADDR_MASK:    rd_mux = zext(mask);
            ADDR_MODE:    rd_mux = zext(mode);
            ADDR_ACTIVE:  rd_mux = zext(active);
            ADDR_VECTOR:  rd_mux = vector;
            ADDR_RAW:     rd_mux = zext(src_d);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_d    <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            src_d    <= s;
            pending  <= pending_nxt;
            irq      <= |active;
            readdata <= rd_mux;
            if (wr_en && (address == ADDR_MASK)) begin
                mask <= wdata;
            end
            if (wr_en && (address == ADDR_MODE)) begin
                mode <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_deca_irq_aggregator.sv
// Bench for deca_irq_aggregator (default build): register vector table plus hand-written
// sequences for irq latency, W1C/edge interaction and asynchronous reset.
module tb_deca_irq_aggregator;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  src;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    deca_irq_aggregator #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .src        (src),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        bit          wr;
        logic [15:0] data;
        logic [7:0]  s;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string name);
        sb_t e;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        tick();
        chipselect = 1'b0;
        e = sb.pop_front();
        check(e.name, readdata, e.exp);
    endtask

    task automatic add(input logic [2:0] a, input bit wr, input logic [15:0] d,
                       input logic [7:0] s, input logic [15:0] exp, input string name);
        vec_t v;
        v.addr = a; v.wr = wr; v.data = d; v.s = s; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        src        = '0;

        for (int a = 0; a < 8; a++) add(3'(a), 0, 16'h0, 8'h00, 16'h0000, "rst_read");
        add(3'd1, 1, 16'hFFFF, 8'h00, 16'h0, "");
        add(3'd1, 0, 16'h0,    8'h00, 16'h00FF, "mask_width");
        add(3'd2, 1, 16'h0F0F, 8'h00, 16'h0, "");
        add(3'd2, 0, 16'h0,    8'h00, 16'h000F, "mode_width");
        add(3'd3, 1, 16'hFFFF, 8'h00, 16'h0, "");
        add(3'd7, 1, 16'hFFFF, 8'h00, 16'h0, "");
        add(3'd4, 1, 16'hFFFF, 8'h00, 16'h0, "");
        add(3'd6, 1, 16'hFFFF, 8'h00, 16'h0, "");
        add(3'd1, 0, 16'h0,    8'h00, 16'h00FF, "ro_wr_mask");
        add(3'd2, 0, 16'h0,    8'h00, 16'h000F, "ro_wr_mode");
        add(3'd1, 1, 16'h0000, 8'h00, 16'h0, "");
        add(3'd2, 1, 16'h00FF, 8'h00, 16'h0, "");
        add(3'd1, 1, 16'h00A0, 8'h00, 16'h0, "");
        add(3'd5, 1, 16'h00E0, 8'h00, 16'h0, "");
        add(3'd0, 0, 16'h0,    8'h00, 16'h00E0, "prio_pending");
        add(3'd3, 0, 16'h0,    8'h00, 16'h00A0, "prio_active");
        add(3'd4, 0, 16'h0,    8'h00, 16'h8005, "prio_vector");
        add(3'd1, 1, 16'h0000, 8'h00, 16'h0, "");
        add(3'd4, 0, 16'h0,    8'h00, 16'h0000, "vector_nomask");
        add(3'd3, 0, 16'h0,    8'h00, 16'h0000, "active_nomask");
        add(3'd0, 1, 16'h00FF, 8'h00, 16'h0, "");
        add(3'd0, 0, 16'h0,    8'h00, 16'h0000, "w1c_all");
        add(3'd7, 0, 16'h0,    8'h5A, 16'h0000, "addr7_read");
        add(3'd6, 0, 16'h0,    8'h5A, 16'h005A, "raw");
        add(3'd0, 0, 16'h0,    8'h5A, 16'h005A, "edge_multi");
        add(3'd0, 1, 16'h00FF, 8'h5A, 16'h0, "");
        add(3'd0, 0, 16'h0,    8'h5A, 16'h0000, "held_high_w1c");
        add(3'd2, 1, 16'h0000, 8'h00, 16'h0, "");
        add(3'd0, 0, 16'h0,    8'h00, 16'h0000, "to_level");
        add(3'd5, 1, 16'h00FF, 8'h00, 16'h0, "");
        add(3'd0, 0, 16'h0,    8'h00, 16'h0000, "force_level");

        #12 reset_n = 1'b1;
        tick();
        check("rst_irq", {15'b0, irq}, 16'h0);

        foreach (tbl[i]) begin
            src = tbl[i].s;
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
            else           do_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end
        check("tbl_irq", {15'b0, irq}, 16'h0);

        // level mode on the timer source
        do_write(3'd1, 16'h0001);
        src = 8'h01;
        tick();
        check("lvl_irq_edge_k", {15'b0, irq}, 16'h0);
        tick();
        check("lvl_irq_edge_k1", {15'b0, irq}, 16'h1);
        do_write(3'd0, 16'h0001);
        do_read(3'd0, 16'h0001, "lvl_w1c_noeffect");
        check("lvl_irq_after_w1c", {15'b0, irq}, 16'h1);
        src = 8'h00;
        tick();
        check("lvl_fall_k", {15'b0, irq}, 16'h1);
        tick();
        check("lvl_fall_k1", {15'b0, irq}, 16'h0);
        do_read(3'd0, 16'h0000, "lvl_pending_low");

        // edge mode on src[2]
        do_write(3'd2, 16'h0004);
        do_write(3'd1, 16'h0004);
        src = 8'h04;
        tick();
        src = 8'h00;
        check("edge_irq_k", {15'b0, irq}, 16'h0);
        tick();
        check("edge_irq_k1", {15'b0, irq}, 16'h1);
        do_read(3'd0, 16'h0004, "edge_pending");
        tick();
        tick();
        check("edge_irq_held", {15'b0, irq}, 16'h1);
        do_write(3'd0, 16'h0004);
        tick();
        check("edge_w1c_irq", {15'b0, irq}, 16'h0);
        do_read(3'd0, 16'h0000, "edge_w1c_pending");
        src = 8'h04;
        do_write(3'd0, 16'h0004);
        do_read(3'd0, 16'h0004, "edge_set_wins");
        do_write(3'd0, 16'h0004);
        do_read(3'd0, 16'h0000, "edge_held_no_reset");
        src = 8'h00;

        // asynchronous reset mid-operation
        do_write(3'd2, 16'h0000);
        do_write(3'd1, 16'h0001);
        src = 8'h01;
        tick();
        tick();
        check("pre_rst_irq", {15'b0, irq}, 16'h1);
        address    = 3'd0;
        chipselect = 1'b1;
        tick();
        check("pre_rst_rd", readdata, 16'h0001);
        reset_n = 1'b0;
        #2;
        check("in_rst_irq", {15'b0, irq}, 16'h0);
        check("in_rst_rd", readdata, 16'h0000);
        #10;
        check("in_rst_rd_clk", readdata, 16'h0000);
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        do_read(3'd1, 16'h0000, "post_rst_mask");
        do_read(3'd0, 16'h0001, "post_rst_pending");
        check("post_rst_irq", {15'b0, irq}, 16'h0);
        src = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
